// File: rtl/uart_sram_tx_interface.sv
// Reads a block of 16-bit SRAM words and sends each one out of UART_TX_O as
// two 8N1 characters, high byte first.
module uart_sram_tx_interface #(
  parameter int CLKS_PER_BIT = 434,
  parameter int READ_LATENCY = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic [17:0] Start_address,
  input  logic [17:0] Word_count,
  input  logic        Abort,
  output logic [17:0] SRAM_address,
  input  logic [15:0] SRAM_read_data,
  output logic        SRAM_we_n,
  output logic        UART_TX_O,
  output logic        Busy,
  output logic        Done
);

  // state   | meaning
  // IDLE    | waiting for Start; line high, SRAM_address held
  // READ    | SRAM_address valid for the current word
  // WAIT    | waiting out the SRAM read latency, then capture the word
  // START   | start bit (line low)
  // DATA    | eight data bits of the selected byte, LSB first
  // STOP    | stop bit (line high), then next byte, next word or finish
  typedef enum logic [2:0] {
    S_TX_IDLE,
    S_TX_READ,
    S_TX_WAIT,
    S_TX_START,
    S_TX_DATA,
    S_TX_STOP
  } tx_state_t;

  localparam int CNT_MAX = (CLKS_PER_BIT > READ_LATENCY) ? CLKS_PER_BIT : READ_LATENCY;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(READ_LATENCY - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  tx_state_t   state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]  bit_idx, bit_n;
  logic        byte_sel, byte_sel_n;
  logic [15:0] word, word_n;
  logic [17:0] addr, addr_n;
  logic [17:0] remaining, rem_n;
  logic [17:0] sram_addr, sram_addr_n;
  logic        abort_q, abort_n;
  logic        zero_pend, zero_pend_n;
  logic        busy_q, busy_n;
  logic        done_q, done_n;
  logic        tx_q, tx_n;
  logic [7:0]  byte_n;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= S_TX_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      byte_sel  <= 1'b0;
      word      <= '0;
      addr      <= '0;
      remaining <= '0;
      sram_addr <= '0;
      abort_q   <= 1'b0;
      zero_pend <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_n;
      byte_sel  <= byte_sel_n;
      word      <= word_n;
      addr      <= addr_n;
      remaining <= rem_n;
      sram_addr <= sram_addr_n;
      abort_q   <= abort_n;
      zero_pend <= zero_pend_n;
      busy_q    <= busy_n;
      done_q    <= done_n;
      tx_q      <= tx_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    bit_n       = bit_idx;
    byte_sel_n  = byte_sel;
    word_n      = word;
    addr_n      = addr;
    rem_n       = remaining;
    sram_addr_n = sram_addr;
    busy_n      = busy_q;
    done_n      = 1'b0;
    zero_pend_n = 1'b0;
    abort_n     = abort_q | (busy_q & Abort);
    byte_n      = 8'h00;
    tx_n        = 1'b1;

    case (state)
      S_TX_IDLE: begin
        cnt_n = '0;
        // A zero-length dump still reports Busy for one cycle, then Done.
        if (zero_pend) begin
          done_n = 1'b1;
          busy_n = 1'b0;
        end else if (Start) begin
          addr_n = Start_address;
          rem_n  = Word_count;
          busy_n = 1'b1;
          if (Word_count == '0) begin
            zero_pend_n = 1'b1;
          end else begin
            state_n     = S_TX_READ;
            sram_addr_n = Start_address;
          end
        end
      end

      S_TX_READ: begin
        cnt_n   = '0;
        state_n = S_TX_WAIT;
      end

      S_TX_WAIT: begin
        if (cnt == WAIT_LAST) begin
          word_n     = SRAM_read_data;
          byte_sel_n = 1'b0;
          cnt_n      = '0;
          state_n    = S_TX_START;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end

      S_TX_START: begin
        if (cnt == BAUD_LAST) begin
          cnt_n   = '0;
          bit_n   = '0;
          state_n = S_TX_DATA;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end

      S_TX_DATA: begin
        if (cnt == BAUD_LAST) begin
          cnt_n = '0;
          if (bit_idx == 3'd7) begin
            state_n = S_TX_STOP;
          end else begin
            bit_n = bit_idx + 3'd1;
          end
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end

      S_TX_STOP: begin
        if (cnt == BAUD_LAST) begin
          cnt_n = '0;
          if (abort_q | Abort) begin
            state_n = S_TX_IDLE;
            done_n  = 1'b1;
            busy_n  = 1'b0;
          end else if (!byte_sel) begin
            byte_sel_n = 1'b1;
            state_n    = S_TX_START;
          end else begin
            rem_n  = remaining - 18'd1;
            addr_n = addr + 18'd1;
            if (remaining == 18'd1) begin
              state_n = S_TX_IDLE;
              done_n  = 1'b1;
              busy_n  = 1'b0;
            end else begin
              state_n     = S_TX_READ;
              sram_addr_n = addr + 18'd1;
            end
          end
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end

      default: begin
        state_n = S_TX_IDLE;
        cnt_n   = '0;
      end
    endcase

    if (done_n) abort_n = 1'b0;

    // Line level is registered from the next-state values so it never glitches.
    byte_n = byte_sel_n ? word_n[7:0] : word_n[15:8];
    if (state_n == S_TX_START) begin
      tx_n = 1'b0;
    end else if (state_n == S_TX_DATA) begin
      tx_n = byte_n[bit_n];
    end
  end

  assign SRAM_address = sram_addr;
  assign SRAM_we_n    = 1'b1;
  assign UART_TX_O    = tx_q;
  assign Busy         = busy_q;
  assign Done         = done_q;

endmodule

// File: tb/tb_uart_sram_tx_interface.sv
// Randomised bench: decodes the serial line and compares every character,
// gap and Done/Busy event against a queue built from the SRAM contents.
module tb_uart_sram_tx_interface;

  localparam int CPB = 4;
  localparam int RL  = 2;
  localparam int FRAME = 10 * CPB;

  logic        clk;
  logic        Reset, Start, Abort;
  logic [17:0] Start_address, Word_count;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_read_data;
  logic        SRAM_we_n, UART_TX_O, Busy, Done;

  uart_sram_tx_interface #(.CLKS_PER_BIT(CPB), .READ_LATENCY(RL)) dut (
    .Clock(clk), .Reset(Reset), .Start(Start), .Start_address(Start_address),
    .Word_count(Word_count), .Abort(Abort), .SRAM_address(SRAM_address),
    .SRAM_read_data(SRAM_read_data), .SRAM_we_n(SRAM_we_n), .UART_TX_O(UART_TX_O),
    .Busy(Busy), .Done(Done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // SRAM model: fixed two-cycle read latency
  logic [15:0] mem [bit [17:0]];
  logic [15:0] rd_d1;

  function automatic logic [15:0] sram_rd(input logic [17:0] a);
    if (mem.exists(a)) return mem[a];
    return a[15:0] ^ 16'h5A5A;
  endfunction

  always @(posedge clk) begin
    rd_d1          <= sram_rd(SRAM_address);
    SRAM_read_data <= rd_d1;
  end

  // Expected characters with the required distance from the previous start bit
  typedef struct {
    logic [7:0] data;
    int         gap;
  } char_t;
  char_t exp_q[$];

  bit    mon_en = 1'b0;
  bit    done_gap_chk = 1'b0;
  bit    in_char = 1'b0;
  int    pos = 0;
  int    cyc = 0;
  int    last_start = 0;
  int    chars = 0;
  int    dones = 0;
  logic  prev_busy = 1'b0;
  logic  prev_done = 1'b0;
  char_t cur;
  logic [9:0] frame;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!mon_en) begin
        in_char = 1'b0;
      end else begin
        if (!in_char && UART_TX_O == 1'b0) begin
          in_char = 1'b1;
          pos     = 0;
          chars++;
          check("char_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) cur = exp_q.pop_front();
          else cur = '{data: 8'h00, gap: -1};
          if (cur.gap >= 0) check("char_gap", 32'(cyc - last_start), 32'(cur.gap));
          last_start = cyc;
          check("we_n", 32'(SRAM_we_n), 32'd1);
        end
        if (in_char) begin
          frame = {1'b1, cur.data, 1'b0};
          check("tx_bit", 32'(UART_TX_O), 32'(frame[4'(pos / CPB)]));
          pos++;
          if (pos == FRAME) in_char = 1'b0;
        end
        if (Done) begin
          dones++;
          check("busy_at_done", 32'(Busy), 32'd0);
          check("busy_before_done", 32'(prev_busy), 32'd1);
          check("done_width", 32'(prev_done), 32'd0);
          if (done_gap_chk) check("done_after_stop", 32'(cyc - last_start), 32'(FRAME));
        end
      end
      prev_busy = Busy;
      prev_done = Done;
    end
  end

  task automatic push_dump(input logic [17:0] sa, input int wc, input int nchars);
    logic [17:0] a;
    logic [15:0] w;
    int k = 0;
    for (int i = 0; i < wc; i++) begin
      a = sa + 18'(i);
      w = sram_rd(a);
      if (k < nchars) exp_q.push_back('{data: w[15:8], gap: (i == 0) ? -1 : FRAME + RL + 1});
      k++;
      if (k < nchars) exp_q.push_back('{data: w[7:0], gap: FRAME});
      k++;
    end
  endtask

  task automatic pulse_start(input logic [17:0] sa, input logic [17:0] wc, input logic ab);
    @(negedge clk);
    Start = 1'b1; Start_address = sa; Word_count = wc; Abort = ab;
    @(negedge clk);
    Start = 1'b0; Abort = 1'b0;
    Start_address = 18'($urandom); Word_count = 18'($urandom);
  endtask

  task automatic wait_done(input int d0, input int lim);
    for (int i = 0; i < lim; i++) begin
      @(posedge clk);
      if (dones > d0) break;
    end
    repeat (20) @(posedge clk);
    check("done_count", 32'(dones - d0), 32'd1);
  endtask

  task automatic run_dump(input logic [17:0] sa, input int wc, input logic ab_with_start,
                          input bit inject);
    int d0, c0;
    logic [17:0] last;
    d0 = dones; c0 = chars;
    push_dump(sa, wc, 2 * wc);
    done_gap_chk = 1'b1;
    pulse_start(sa, 18'(wc), ab_with_start);
    check("busy_after_start", 32'(Busy), 32'd1);
    if (inject) begin
      repeat (30) @(negedge clk);
      Start = 1'b1; Start_address = 18'h00100; Word_count = 18'd5;
      @(negedge clk);
      Start = 1'b0;
    end
    wait_done(d0, wc * (2 * FRAME + RL + 1) + 60);
    check("char_count", 32'(chars - c0), 32'(2 * wc));
    check("exp_drained", 32'(exp_q.size()), 32'd0);
    last = sa + 18'(wc - 1);
    check("addr_hold", 32'(SRAM_address), 32'(last));
    check("busy_idle", 32'(Busy), 32'd0);
  endtask

  task automatic fill_block(input logic [17:0] sa, input int wc);
    logic [17:0] a;
    for (int i = 0; i < wc; i++) begin
      a = sa + 18'(i);
      mem[a] = 16'($urandom);
    end
  endtask

  initial begin
    int d0, c0, n;
    logic [17:0] sa;

    Reset = 1'b1; Start = 1'b0; Abort = 1'b0;
    Start_address = '0; Word_count = '0;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(UART_TX_O), 32'd1);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_addr", 32'(SRAM_address), 32'd0);
    check("rst_we_n", 32'(SRAM_we_n), 32'd1);
    Reset = 1'b0;
    mon_en = 1'b1;

    // Directed: one word 0xA53C
    mem[18'h00010] = 16'hA53C;
    run_dump(18'h00010, 1, 1'b0, 1'b0);

    // Wrap across the top of the address space
    fill_block(18'h3FFFF, 3);
    run_dump(18'h3FFFF, 3, 1'b0, 1'b0);

    // Zero-length dump
    d0 = dones; c0 = chars;
    done_gap_chk = 1'b0;
    pulse_start(18'h00020, 18'd0, 1'b0);
    check("zero_busy1", 32'(Busy), 32'd1);
    check("zero_done1", 32'(Done), 32'd0);
    @(negedge clk);
    check("zero_done2", 32'(Done), 32'd1);
    check("zero_busy2", 32'(Busy), 32'd0);
    @(negedge clk);
    check("zero_done3", 32'(Done), 32'd0);
    repeat (30) @(negedge clk);
    check("zero_chars", 32'(chars - c0), 32'd0);
    check("zero_done_count", 32'(dones - d0), 32'd1);

    // Abort during bit 3 of the first byte of a 4-word dump
    fill_block(18'h00200, 4);
    d0 = dones; c0 = chars;
    push_dump(18'h00200, 4, 1);
    done_gap_chk = 1'b1;
    pulse_start(18'h00200, 18'd4, 1'b0);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (chars > c0 && pos >= 4 * CPB) break;
    end
    @(negedge clk); Abort = 1'b1;
    @(negedge clk); Abort = 1'b0;
    wait_done(d0, 100);
    repeat (60) @(posedge clk);
    check("abort_chars", 32'(chars - c0), 32'd1);
    check("abort_drained", 32'(exp_q.size()), 32'd0);
    check("abort_busy", 32'(Busy), 32'd0);

    // Second Start during an active dump is ignored
    fill_block(18'h00050, 2);
    run_dump(18'h00050, 2, 1'b0, 1'b1);

    // Randomised dumps, some with Abort alongside Start or a stray Start
    for (int it = 0; it < 8; it++) begin
      sa = ($urandom_range(0, 2) == 0) ? 18'(18'h3FFFF - $urandom_range(0, 2)) : 18'($urandom);
      n  = $urandom_range(1, 3);
      fill_block(sa, n);
      run_dump(sa, n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of the data bits
    fill_block(18'h01000, 3);
    c0 = chars;
    push_dump(18'h01000, 3, 6);
    pulse_start(18'h01000, 18'd3, 1'b0);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (chars > c0 && pos >= 3 * CPB) break;
    end
    mon_en = 1'b0;
    exp_q.delete();
    d0 = dones;
    @(negedge clk); Reset = 1'b1;
    @(negedge clk);
    check("mid_rst_tx", 32'(UART_TX_O), 32'd1);
    check("mid_rst_busy", 32'(Busy), 32'd0);
    check("mid_rst_done", 32'(Done), 32'd0);
    repeat (2) @(negedge clk);
    Reset = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      check("post_rst_line", 32'({UART_TX_O, Busy, Done}), 32'b100);
    end
    check("post_rst_dones", 32'(dones - d0), 32'd0);
    mon_en = 1'b1;

    // Recovery after reset
    fill_block(18'h02000, 2);
    run_dump(18'h02000, 2, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_sram_tx_interface.md
Name: uart_sram_tx_interface

Overview:
- Transmit-side counterpart of the UART receive path: reads a block of 16-bit words from SRAM and serialises them out of the UART TX pin as 8N1 bytes.
- Each word is sent high byte first, then low byte.
- Sits beside the VGA and UART-RX units. The top-level FSM grants it the SRAM address bus while it is busy, and drives its TX output onto the UART TX pin.
- Read-only on SRAM: it never writes.

Parameters:
- CLKS_PER_BIT, 434: clock cycles per UART bit (50 MHz / 115200 baud).
- READ_LATENCY, 2: cycles from SRAM_address valid to SRAM_read_data valid; fixed by the SRAM controller.

Ports:
- Clock  input  1  system clock, 50 MHz.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  one-cycle pulse that starts a dump; ignored while Busy=1.
- Start_address  input  18  first SRAM word address; sampled on Start.
- Word_count  input  18  number of words to send; sampled on Start.
- Abort  input  1  ends the dump after the byte currently on the line finishes its stop bit.
- SRAM_address  output  18  read address to the SRAM controller.
- SRAM_read_data  input  16  read data from the SRAM controller.
- SRAM_we_n  output  1  tied high.
- UART_TX_O  output  1  serial line; idles high.
- Busy  output  1  high from the cycle after Start until Done.
- Done  output  1  one-cycle pulse when the dump ends (normal completion or abort).

Behaviour:
- Only one clock domain. Reset is synchronous and active-high. Everything below is sampled on the rising edge of Clock.
- Reset values:
  - UART_TX_O=1, Busy=0, Done=0, SRAM_address=0, SRAM_we_n=1.
  - State S_TX_IDLE; internal counters 0.
- Reset mid-dump: on the next edge, the line returns high immediately, even if that truncates a character.
- State machine:
  - S_TX_IDLE: on Start, latch Start_address into an address register and Word_count into a remaining-count register, and set Busy. If Word_count=0, pulse Done on the next cycle and stay idle with Busy=0. Otherwise go to S_TX_READ.
  - S_TX_READ: drive SRAM_address from the address register; go to S_TX_WAIT.
  - S_TX_WAIT: hold SRAM_address. After READ_LATENCY cycles counted from S_TX_READ, capture SRAM_read_data into a 16-bit word register, clear byte_sel to 0 (high byte), and go to S_TX_START.
  - S_TX_START: UART_TX_O=0 for CLKS_PER_BIT cycles, then go to S_TX_DATA with bit index 0.
  - S_TX_DATA: send the selected byte LSB first, each bit held for CLKS_PER_BIT cycles. After bit 7, go to S_TX_STOP.
  - S_TX_STOP: UART_TX_O=1 for CLKS_PER_BIT cycles, then:
    - if Abort has been latched: go to S_TX_IDLE and pulse Done;
    - else if byte_sel=0: set byte_sel=1 and go to S_TX_START, with no re-read;
    - else: decrement remaining count and increment address (wraps 18'h3FFFF to 0). If the count is now 0, go to S_TX_IDLE and pulse Done; otherwise go to S_TX_READ.
- Baud counter: counts 0..CLKS_PER_BIT-1 and resets on every state entry. Bit boundaries are exact, with no cumulative drift.
- Line idle between characters:
  - between the high and low byte of one word: no extra idle cycles;
  - between words: READ_LATENCY+1 cycles of idle-high.
- Abort:
  - latched whenever Busy=1 and cleared on Done;
  - Abort in S_TX_IDLE is ignored;
  - Abort together with Start in the same cycle: Start wins and Abort is ignored.
- Start while Busy=1 is ignored, and the latched parameters are unchanged.
- Done and Busy timing: Done is high for exactly one cycle. Busy falls in the same cycle that Done rises.
- SRAM_address holds its last value while idle, so the top-level mux sees a stable bus.

Test Plan:
- Reset=1 for 3 cycles in the middle of the data bits -> UART_TX_O=1, Busy=0, Done=0 on the first edge after Reset; no further transitions.
- CLKS_PER_BIT=4, preload SRAM[0x00010]=16'hA53C; Start, Start_address=0x00010, Word_count=1 -> line shows start bit, bits 1,0,1,0,0,1,0,1 (0xA5 LSB first), stop bit, then start bit, 0,0,1,1,1,1,0,0 (0x3C), stop bit. Each bit is 4 cycles. Done pulses once and SRAM_we_n stays 1 throughout.
- Word_count=3, Start_address=0x3FFFF -> reads 0x3FFFF, then 0x00000, then 0x00001; 6 bytes are sent; Done after the 6th stop bit.
- Word_count=0 -> no line activity; Done pulses 1 cycle after Start; Busy high for exactly 1 cycle.
- Abort pulsed during bit 3 of the first byte of a 4-word dump -> the first byte completes with its stop bit, then Done; only 1 byte appears on the line.
- Second Start during an active dump with Start_address=0x00100 -> ignored; addresses continue from the original block; Done pulses exactly once.
